// File: rtl/match_point_gen_pkg.sv
// Shared definitions for the match-point generator: geometry defaults,
// sweep state encoding, point ordering and the coordinate clamp helper.
package match_pkg;

    localparam int W     = 14;
    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int DELTA = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int PT_RIGHT = 0;
    localparam int PT_DOWN  = 1;
    localparam int PT_LEFT  = 2;
    localparam int PT_UP    = 3;

    typedef struct packed {
        logic [W-1:0] x0;
        logic [W-1:0] y0;
        logic [W-1:0] x1;
        logic [W-1:0] y1;
        logic [W-1:0] r_min;
        logic [W-1:0] r_max;
        logic [W-1:0] r_step;
    } sweep_cfg_t;

    // Clamp a signed coordinate into [0, hi] and narrow it to W bits.
    function automatic logic [W-1:0] clamp_coord(input logic signed [W+1:0] v,
                                                 input logic signed [W+1:0] hi);
        logic [W-1:0] res;
        if (v[W+1]) begin
            res = '0;
        end else if (v > hi) begin
            res = hi[W-1:0];
        end else begin
            res = v[W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/match_point_gen_if.sv
// Candidate output bus of match_point_gen: valid/ready handshake plus the
// centre and the packed inner/outer sample points.
interface match_point_gen_if;
    import match_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     xb_o;
    logic [W-1:0]     yb_o;
    logic [4*W-1:0]   new_xi;
    logic [4*W-1:0]   new_yi;
    logic [4*W-1:0]   new_xo;
    logic [4*W-1:0]   new_yo;

    modport master (
        output out_valid, xb_o, yb_o, new_xi, new_yi, new_xo, new_yo,
        input  out_ready
    );

    modport slave (
        input  out_valid, xb_o, yb_o, new_xi, new_yi, new_xo, new_yo,
        output out_ready
    );

endinterface

// File: rtl/match_point_gen_point_ring_calc.sv
// Combinational ring of four sample points (right/down/left/up) around a
// centre at a given radius, clamped into the image, plus a flag telling
// whether every unclamped point already lay inside the image.
module point_ring_calc
    import match_pkg::*;
(
    input  logic [W-1:0]   cx,
    input  logic [W-1:0]   cy,
    input  logic [W:0]     rad,
    output logic [4*W-1:0] px,
    output logic [4*W-1:0] py,
    output logic           in_bounds
);

    localparam logic signed [W+1:0] X_MAX = (W+2)'(IMG_W - 1);
    localparam logic signed [W+1:0] Y_MAX = (W+2)'(IMG_H - 1);

    logic signed [W+1:0] sx;
    logic signed [W+1:0] sy;
    logic signed [W+1:0] sr;
    logic signed [W+1:0] raw_x [4];
    logic signed [W+1:0] raw_y [4];

    // Compute raw signed points, then clamp and pack them, point 0 in the LSBs.
    always_comb begin
        sx = $signed({2'b00, cx});
        sy = $signed({2'b00, cy});
        sr = $signed({1'b0, rad});

        raw_x[PT_RIGHT] = sx + sr;
        raw_y[PT_RIGHT] = sy;
        raw_x[PT_DOWN]  = sx;
        raw_y[PT_DOWN]  = sy + sr;
        raw_x[PT_LEFT]  = sx - sr;
        raw_y[PT_LEFT]  = sy;
        raw_x[PT_UP]    = sx;
        raw_y[PT_UP]    = sy - sr;

        px        = '0;
        py        = '0;
        in_bounds = 1'b1;
        for (int i = 0; i < 4; i++) begin
            px[i*W +: W] = clamp_coord(raw_x[i], X_MAX);
            py[i*W +: W] = clamp_coord(raw_y[i], Y_MAX);
            if (raw_x[i][W+1] || (raw_x[i] > X_MAX) ||
                raw_y[i][W+1] || (raw_y[i] > Y_MAX)) begin
                in_bounds = 1'b0;
            end
        end
    end

endmodule

// File: rtl/match_point_gen.sv
// Candidate generator feeding ram_control_5ram: sweeps centres over an ROI
// and radii over a range, presenting one (centre, radius) candidate with its
// inner and outer sample rings per valid/ready handshake.
// Optional build macro MPG_BORDER_SKIP_EN: candidates whose outer ring leaves
// the image are dropped (one idle cycle each) instead of being clamped.
module match_point_gen
    import match_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      roi_x0,
    input  logic [W-1:0]      roi_y0,
    input  logic [W-1:0]      roi_x1,
    input  logic [W-1:0]      roi_y1,
    input  logic [W-1:0]      r_min,
    input  logic [W-1:0]      r_max,
    input  logic [W-1:0]      r_step,
    match_point_gen_if.master bus,
    output logic              busy,
    output logic              done
);

    logic [1:0]     state_q, state_d;
    sweep_cfg_t     cfg_q, cfg_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d, r_q, r_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   xb_q, xb_d, yb_q, yb_d;
    logic [4*W-1:0] xi_q, xi_d, yi_q, yi_d, xo_q, xo_d, yo_q, yo_d;

    logic           load;
    logic [W:0]     r_inc, x_inc, y_inc;
    logic [4*W-1:0] in_px, in_py, out_px, out_py;
    logic           inner_ok, outer_ok;

    // Sweep control: latch config on start, step r then x then y on each
    // consumed candidate, and flag when a fresh candidate must be loaded.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        load    = 1'b0;
        r_inc   = {1'b0, r_q} + {1'b0, cfg_q.r_step};
        x_inc   = {1'b0, x_q} + {{W{1'b0}}, 1'b1};
        y_inc   = {1'b0, y_q} + {{W{1'b0}}, 1'b1};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d.x0     = roi_x0;
                    cfg_d.y0     = roi_y0;
                    cfg_d.x1     = roi_x1;
                    cfg_d.y1     = roi_y1;
                    cfg_d.r_min  = r_min;
                    cfg_d.r_max  = r_max;
                    cfg_d.r_step = (r_step == '0) ? {{(W-1){1'b0}}, 1'b1} : r_step;
                    x_d = roi_x0;
                    y_d = roi_y0;
                    r_d = r_min;
                    if ((roi_x1 < roi_x0) || (roi_y1 < roi_y0) || (r_max < r_min)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                        load    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!out_valid_q || bus.out_ready) begin
                    if (r_inc <= {1'b0, cfg_q.r_max}) begin
                        r_d = r_inc[W-1:0];
                    end else begin
                        r_d = cfg_q.r_min;
                        if (x_inc <= {1'b0, cfg_q.x1}) begin
                            x_d = x_inc[W-1:0];
                        end else begin
                            x_d = cfg_q.x0;
                            if (y_inc <= {1'b0, cfg_q.y1}) begin
                                y_d = y_inc[W-1:0];
                            end else begin
                                state_d = ST_FIN;
                            end
                        end
                    end
                    load = (state_d == ST_RUN);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    point_ring_calc u_inner (
        .cx        (x_d),
        .cy        (y_d),
        .rad       ({1'b0, r_d}),
        .px        (in_px),
        .py        (in_py),
        .in_bounds (inner_ok)
    );

    point_ring_calc u_outer (
        .cx        (x_d),
        .cy        (y_d),
        .rad       ({1'b0, r_d} + (W+1)'(DELTA)),
        .px        (out_px),
        .py        (out_py),
        .in_bounds (outer_ok)
    );

`ifdef MPG_BORDER_SKIP_EN
    logic unused_bounds;
    assign unused_bounds = inner_ok;
`else
    logic unused_bounds;
    assign unused_bounds = inner_ok ^ outer_ok;
`endif

    // Output register next values: capture the new candidate when loading,
    // hold under backpressure, drop valid once the sweep leaves RUN.
    always_comb begin
        out_valid_d = out_valid_q;
        xb_d        = xb_q;
        yb_d        = yb_q;
        xi_d        = xi_q;
        yi_d        = yi_q;
        xo_d        = xo_q;
        yo_d        = yo_q;
        if (load) begin
            xb_d = x_d;
            yb_d = y_d;
            xi_d = in_px;
            yi_d = in_py;
            xo_d = out_px;
            yo_d = out_py;
`ifdef MPG_BORDER_SKIP_EN
            out_valid_d = outer_ok;
`else
            out_valid_d = 1'b1;
`endif
        end else if (state_d != ST_RUN) begin
            out_valid_d = 1'b0;
        end
    end

    // State, counters, latched config and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            xb_q        <= '0;
            yb_q        <= '0;
            xi_q        <= '0;
            yi_q        <= '0;
            xo_q        <= '0;
            yo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            x_q         <= x_d;
            y_q         <= y_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            xb_q        <= xb_d;
            yb_q        <= yb_d;
            xi_q        <= xi_d;
            yi_q        <= yi_d;
            xo_q        <= xo_d;
            yo_q        <= yo_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.xb_o      = xb_q;
    assign bus.yb_o      = yb_q;
    assign bus.new_xi    = xi_q;
    assign bus.new_yi    = yi_q;
    assign bus.new_xo    = xo_q;
    assign bus.new_yo    = yo_q;
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_FIN);

endmodule

// File: doc/match_point_gen.md
Name: match_point_gen

Overview:
- Upstream stage of ram_control_5ram.
- Sweeps candidate centres over a region of interest (ROI) and, per centre, over a radius range.
- For each (centre, radius) candidate it emits the centre (xb_o, yb_o), four inner sample points and four outer sample points.
- Points are ordered right/down/left/up and feed the RAM address generator for matching-score evaluation.
- One candidate is emitted per accepted valid/ready handshake.

Parameters:
- W, 14, coordinate width.
- IMG_W, 640, image width in pixels; x range 0..IMG_W-1.
- IMG_H, 480, image height in pixels; y range 0..IMG_H-1.
- DELTA, 4, outer radius = inner radius + DELTA.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; latches configuration and begins the sweep.
- roi_x0, roi_y0, roi_x1, roi_y1  in  W each  inclusive ROI bounds.
- r_min, r_max, r_step  in  W each  radius sweep range and step.
- out_ready  in  1  downstream accepts the current candidate.
- out_valid  out  1  candidate outputs are valid.
- xb_o, yb_o  out  W each  candidate centre.
- new_xi, new_yi, new_xo, new_yo  out  4*W each  packed points; point 0 in bits [W-1:0], point 3 in the MSBs.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset: clk rising edge with rst=1 forces:
  - state IDLE;
  - out_valid, busy, done and all coordinate outputs to 0.
- Reset mid-sweep aborts with no done pulse.
- States are IDLE, RUN, FIN.
- IDLE:
  - start=1 latches all config inputs; r_step=0 is latched as 1.
  - Initialises x=roi_x0, y=roi_y0, r=r_min.
  - If roi_x1<roi_x0, roi_y1<roi_y0 or r_max<r_min, goes to FIN (empty sweep, no valid).
  - Otherwise goes to RUN with out_valid=1 on the next cycle.
  - First candidate latency is 1 cycle after start.
- start is ignored outside IDLE. Config inputs are not sampled except at start.
- RUN:
  - Outputs are registered and hold stable while out_valid=1 and out_ready=0.
  - On handshake (out_valid & out_ready) the next candidate appears the next cycle; sustained throughput is 1 per cycle.
  - Loop order, innermost first: r, then x, then y.
  - r advances by r_step; when r+r_step>r_max, r resets to r_min and x increments.
  - When x>roi_x1, x resets to roi_x0 and y increments.
  - The handshake on the candidate (roi_x1, roi_y1, last r) transitions to FIN, with out_valid=0 the next cycle.
  - Sweep length = nx*ny*nr, where nx=roi_x1-roi_x0+1, ny=roi_y1-roi_y0+1, nr=floor((r_max-r_min)/r_step)+1.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in RUN only.
- Point geometry for centre (x, y), radius r, outer radius ro=r+DELTA:
  - pt0 = (x+r, y), right;
  - pt1 = (x, y+r), down;
  - pt2 = (x-r, y), left;
  - pt3 = (x, y-r), up.
  - Outer points use the same geometry with ro.
  - xb_o = x, yb_o = y.
- Arithmetic:
  - Computed signed at W+2 bits.
  - Results clamped to [0, IMG_W-1] for x and [0, IMG_H-1] for y, then truncated to W bits.
- Counter increments are computed at W+1 bits so that r_max or roi_x1 near 2^W-1 cannot wrap and loop forever.

Optional Feature:
- Macro: MPG_BORDER_SKIP_EN.
- Defined:
  - A candidate is skipped if any unclamped outer point lies outside the image.
  - A skipped candidate consumes one cycle with out_valid=0 and is never presented.
  - If the final candidate is skipped, FIN still follows.
- Undefined: all candidates are presented with clamping as above.

Decomposition:
- Shared package (match_pkg): W, IMG_W, IMG_H, DELTA defaults; state encoding; point-index constants (PT_RIGHT=0, PT_DOWN=1, PT_LEFT=2, PT_UP=3).
- Sub-module point_ring_calc:
  - Purely combinational.
  - Maps centre and radius to the 4 clamped points plus an in_bounds flag.
  - Instantiated twice, once for inner and once for outer points.
- The sweep FSM and counters stay in match_point_gen.

Test Plan:
- Basic sweep, ROI x 100..101, y 50..50, r 10..11, step 1, out_ready=1:
  - exactly 4 candidates in order (100,10), (100,11), (101,10), (101,11);
  - first candidate: xi={100,90,100,110}, yi={40,50,60,50}, xo0=114, yo3=36 (MSB->LSB packing);
  - done 1 cycle after the 4th handshake.
- Clamp, centre (2,2), r=5, DELTA=4: xi2=0, yi3=0, xo2=0, yo3=0, xi0=7, xo0=11.
- Backpressure: out_ready=0 for 3 cycles mid-sweep -> all outputs stable; no candidate lost or duplicated; total count unchanged.
- Empty config, roi_x1=99 < roi_x0=100 -> out_valid never 1; done 1 cycle after start; a start pulse during RUN is ignored.
- Reset mid-sweep, rst after 2nd handshake:
  - out_valid=0, busy=0 next cycle, no done;
  - a new start restarts from roi_x0, roi_y0, r_min.
- MPG_BORDER_SKIP_EN, ROI x 0..2, y 10, r=3, DELTA=4: only x=... none valid (outer left <0); with x 0..8, only x=7,8 presented, then done.
